// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_pkg
//  Description : Shared constants and result record for the full_adder slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package full_adder_pkg;

    localparam int C_DEFAULT_WIDTH = 5;
    localparam int C_MAX_WIDTH     = 32;

    // The sum field is sized for the widest legal operand; narrower
    // instances leave the upper bits at zero.
    typedef struct packed {
        logic [C_MAX_WIDTH-1:0] sum;
        logic                   c_out;
        logic                   overflow;
    } result_t;

endpackage : full_adder_pkg
`default_nettype wire

// File: rtl/bit_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bit_full_adder
//  Description : Single-bit combinational full adder, one ripple-chain stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_half;

    assign w_half = a ^ b;
    assign s      = w_half ^ cin;
    assign cout   = (a & b) | (w_half & cin);

endmodule : bit_full_adder
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : WIDTH-bit ripple-carry adder with registered sum, carry,
//                signed overflow and a result-valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_overflow;
    result_t          w_next;
    result_t          r_result;
    logic             r_out_valid;

    assign w_carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bit_full_adder u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_carry[i]),
            .s    (w_sum[i]),
            .cout (w_carry[i+1])
        );
    end

    // Signed overflow: like-signed operands producing a result of the other sign.
    assign w_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        w_next              = '0;
        w_next.sum[WIDTH-1:0] = w_sum;
        w_next.c_out        = w_carry[WIDTH];
        w_next.overflow     = w_overflow;
    end

    // Inputs are only sampled under in_valid, so idle-cycle X never reaches the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            r_result    <= w_next;
            r_out_valid <= 1'b1;
        end else begin
            r_result    <= r_result;
            r_out_valid <= 1'b0;
        end
    end

    assign sum       = r_result.sum[WIDTH-1:0];
    assign c_out     = r_result.c_out;
    assign overflow  = r_result.overflow;
    assign out_valid = r_out_valid;

endmodule : full_adder
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_adder
//  Description : Directed and exhaustive self-checking bench for full_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder;

    localparam int WIDTH = 5;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    full_adder #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, then land just after the next rising edge.
    task automatic apply(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tc, input logic tv, input logic tr);
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        c_in     = tc;
        in_valid = tv;
        rst      = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [WIDTH-1:0] es,
                              input logic ec, input logic eo, input logic ev);
        check({tag, ".sum"},       32'(sum),       32'(es));
        check({tag, ".c_out"},     32'(c_out),     32'(ec));
        check({tag, ".overflow"},  32'(overflow),  32'(eo));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    endtask

    initial begin
        int               tot;
        logic [5:0]       tot6;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        logic             ec;
        logic             eovf;

        a = '0; b = '0; c_in = 1'b0; in_valid = 1'b0; rst = 1'b1;

        apply(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1);
        expect_out("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
        apply(5'b11111, 5'b11111, 1'b1, 1'b1, 1'b1);
        expect_out("reset_over_valid", 5'b00000, 1'b0, 1'b0, 1'b0);

        apply(5'b01111, 5'b01000, 1'b0, 1'b1, 1'b0);
        expect_out("pos_ovf", 5'b10111, 1'b0, 1'b1, 1'b1);
        apply(5'b11111, 5'b00001, 1'b0, 1'b1, 1'b0);
        expect_out("wrap_one", 5'b00000, 1'b1, 1'b0, 1'b1);
        apply(5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0);
        expect_out("all_ones", 5'b11111, 1'b1, 1'b0, 1'b1);
        apply(5'b10000, 5'b10000, 1'b0, 1'b1, 1'b0);
        expect_out("neg_ovf", 5'b00000, 1'b1, 1'b1, 1'b1);
        apply(5'b00000, 5'b00000, 1'b1, 1'b1, 1'b0);
        expect_out("cin_only", 5'b00001, 1'b0, 1'b0, 1'b1);

        // Three back-to-back operations, then idle with undriven operands.
        apply(5'd3, 5'd4, 1'b0, 1'b1, 1'b0);
        expect_out("stream0", 5'b00111, 1'b0, 1'b0, 1'b1);
        apply(5'd10, 5'd10, 1'b1, 1'b1, 1'b0);
        expect_out("stream1", 5'b10101, 1'b0, 1'b1, 1'b1);
        apply(5'd20, 5'd20, 1'b0, 1'b1, 1'b0);
        expect_out("stream2", 5'b01000, 1'b1, 1'b1, 1'b1);
        apply('x, 'x, 1'bx, 1'b0, 1'b0);
        expect_out("idle0", 5'b01000, 1'b1, 1'b1, 1'b0);
        apply('x, 'x, 1'bx, 1'b0, 1'b0);
        expect_out("idle1", 5'b01000, 1'b1, 1'b1, 1'b0);

        // Every operand combination back-to-back, with a reset pulse mid-stream.
        for (int i = 0; i < 2048; i++) begin
            if (i == 1024) begin
                apply(5'b10101, 5'b01010, 1'b1, 1'b1, 1'b1);
                expect_out("mid_reset", 5'b00000, 1'b0, 1'b0, 1'b0);
                apply(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
                expect_out("post_reset_idle", 5'b00000, 1'b0, 1'b0, 1'b0);
            end
            ea   = WIDTH'(i >> 6);
            eb   = WIDTH'(i >> 1);
            ec   = i[0];
            tot  = int'(ea) + int'(eb) + int'(ec);
            tot6 = tot[5:0];
            eovf = (ea[4] == eb[4]) && (tot6[4] != ea[4]);
            apply(ea, eb, ec, 1'b1, 1'b0);
            expect_out($sformatf("exh_%0d", i), tot6[4:0], tot6[5], eovf, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_full_adder
`default_nettype wire

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 5, operand and sum width in bits (legal range 1..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high; sampled on rising clk.
REQ-004 a  input  WIDTH  operand A, unsigned (also interpreted two's-complement for overflow).
REQ-005 b  input  WIDTH  operand B, same interpretation as a.
REQ-006 c_in  input  1  carry into bit 0.
REQ-007 in_valid  input  1  a/b/c_in valid this cycle.
REQ-008 sum  output  WIDTH  registered (a + b + c_in) mod 2^WIDTH.
REQ-009 c_out  output  1  registered carry out of bit WIDTH-1.
REQ-010 overflow  output  1  registered signed overflow: operand MSBs equal and sum MSB differs.
REQ-011 out_valid  output  1  sum/c_out/overflow hold a new result.

Function
REQ-012 Addition SHALL be a ripple-carry chain: bit i carry-in = carry-out of bit i-1; bit 0 carry-in = c_in.
REQ-013 {c_out, sum} SHALL equal a + b + c_in exactly, computed at WIDTH+1 bits, no truncation of carry.
REQ-014 Latency SHALL be 1 cycle: inputs sampled at edge N with in_valid=1 appear on outputs after edge N, out_valid=1.
REQ-015 When in_valid=0 at an edge, sum/c_out/overflow SHALL hold previous values and out_valid SHALL go 0.
REQ-016 Back-to-back in_valid=1 SHALL give one result per cycle; no stalls, no backpressure.
REQ-017 Operands narrower than WIDTH at the source SHALL be zero-extended by the driver; the block performs no extension.
REQ-018 Wrap-around: all-ones + all-ones + 1 SHALL give sum=all-ones, c_out=1.
REQ-019 overflow SHALL be derived from a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1] of the same operation; independent of c_out.
REQ-020 Unknown/X on inputs while in_valid=0 SHALL NOT propagate to outputs.

Reset
REQ-021 rst=1 at an edge SHALL force sum=0, c_out=0, overflow=0, out_valid=0, overriding in_valid.
REQ-022 Reset asserted mid-stream SHALL discard the operation sampled that edge; the first valid result after release appears 1 cycle after the first in_valid=1 edge with rst=0.
REQ-023 No asynchronous behaviour; outputs change only on rising clk.

Structure
REQ-024 Shared package SHALL hold the default WIDTH constant and the result record type {sum, c_out, overflow}.
REQ-025 One sub-module bit_full_adder (a, b, cin -> s, cout, purely combinational) SHALL be instantiated WIDTH times via generate.
REQ-026 Top level SHALL contain only the generate chain, overflow logic and the output register stage.

Verification
REQ-027 rst=1 one cycle, a=0,b=0,c_in=0 -> sum=0, c_out=0, overflow=0, out_valid=0.
REQ-028 a=5'b01111, b=5'b01000, c_in=0, in_valid=1 -> next cycle sum=5'b10111, c_out=0, overflow=1, out_valid=1.
REQ-029 a=5'b11111, b=5'b00001, c_in=0 -> sum=5'b00000, c_out=1, overflow=0.
REQ-030 a=5'b11111, b=5'b11111, c_in=1 -> sum=5'b11111, c_out=1, overflow=0.
REQ-031 Stream 3 consecutive valid ops then in_valid=0 -> 3 consecutive results, then outputs hold, out_valid=0.
REQ-032 Exhaustive 2^11 combinations for WIDTH=5 vs. reference model {c_out,sum}=a+b+c_in; rst mid-stream per REQ-022.
